// File: rtl/nbitexp_pkg.sv
// Shared definitions for the nbitexp exponential approximator.
package nbitexp_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/nbitdiv_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// The first step runs on the load edge, so ready pulses WIDTH cycles later.
module nbitdiv_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic [CW-1:0]      cnt_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] step_d;

  // quo carries the remaining dividend bits out of its MSB and shifts
  // quotient bits in at its LSB.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                 input logic [WIDTH-1:0] quo,
                                                 input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[WIDTH])
      div_step = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    else
      div_step = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    step_d = '0;
    if (load)
      step_d = div_step('0, dividend, divisor);
    else
      step_d = div_step(rem_q, quo_q, dvs_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (load) begin
        cnt_q <= CW'(WIDTH - 1);
      end else if (cnt_q != '0) begin
        cnt_q   <= cnt_q - CW'(1);
        ready_q <= (cnt_q == CW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      {rem_q, quo_q} <= step_d;
      dvs_q          <= divisor;
    end else if (cnt_q != '0) begin
      {rem_q, quo_q} <= step_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ready     = ready_q;

endmodule

// File: rtl/nbitexp.sv
// Multi-cycle truncated-Taylor e^x approximator with start/done handshake.
// Build option NBITEXP_SAT_EN: saturate out to all ones on overflow.
module nbitexp
  import nbitexp_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int TERMS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam int KW = $clog2(TERMS + 1);

`ifdef NBITEXP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e             state_q;
  logic [WIDTH-1:0]   x_q, term_q, sum_q;
  logic [KW-1:0]      k_q;
  logic               done_q, ovf_out_q;
  logic [WIDTH-1:0]   out_q;

  logic [2*WIDTH-1:0] prod;
  logic               mul_ovf;
  logic               div_load, div_ready;
  logic [WIDTH-1:0]   div_quo, div_rem_unused;
  logic [WIDTH:0]     acc_sum;

  function automatic logic [WIDTH-1:0] result_f(input logic [WIDTH-1:0] s,
                                               input logic ovf);
    result_f = (ovf && SAT_EN) ? '1 : s;
  endfunction

  assign prod     = (2*WIDTH)'(term_q) * (2*WIDTH)'(x_q);
  assign mul_ovf  = |prod[2*WIDTH-1:WIDTH];
  assign div_load = (state_q == S_MUL) && !mul_ovf;
  assign acc_sum  = {1'b0, sum_q} + {1'b0, div_quo};

  nbitdiv_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (prod[WIDTH-1:0]),
    .divisor   (WIDTH'(k_q)),
    .quotient  (div_quo),
    .remainder (div_rem_unused),
    .ready     (div_ready)
  );

  // Results are registered on entry to DONE so done, out and overflow align.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      out_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= ain;
            term_q  <= WIDTH'(1);
            sum_q   <= WIDTH'(1);
            k_q     <= KW'(1);
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (mul_ovf) begin
            done_q    <= 1'b1;
            out_q     <= result_f(sum_q, 1'b1);
            ovf_out_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (div_ready)
            state_q <= S_ACC;
        end
        S_ACC: begin
          sum_q <= acc_sum[WIDTH-1:0];
          if (acc_sum[WIDTH]) begin
            done_q    <= 1'b1;
            out_q     <= result_f(acc_sum[WIDTH-1:0], 1'b1);
            ovf_out_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (div_quo == '0 || k_q == KW'(TERMS)) begin
            done_q    <= 1'b1;
            out_q     <= result_f(acc_sum[WIDTH-1:0], 1'b0);
            ovf_out_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            k_q     <= k_q + KW'(1);
            term_q  <= div_quo;
            state_q <= S_MUL;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign out      = out_q;
  assign overflow = ovf_out_q;

endmodule

// File: tb/tb_nbitexp.sv
// Directed bench for nbitexp: default instance (TERMS=2) plus a TERMS=4 instance.
module tb_nbitexp;

  logic       clk = 1'b0;
  logic       rst, start, start4;
  logic [5:0] ain, ain4;
  logic       busy, done, overflow;
  logic       busy4, done4, overflow4;
  logic [5:0] out, out4;

  int errors = 0;
  int checks = 0;

`ifdef NBITEXP_SAT_EN
  localparam logic [5:0] EXP_MUL_OVF = 6'd63;
  localparam logic [5:0] EXP_ADD_OVF = 6'd63;
`else
  localparam logic [5:0] EXP_MUL_OVF = 6'd11;
  localparam logic [5:0] EXP_ADD_OVF = 6'd0;
`endif

  always #5 clk = ~clk;

  nbitexp #(.WIDTH(6), .TERMS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .ain(ain),
    .busy(busy), .done(done), .out(out), .overflow(overflow)
  );

  nbitexp #(.WIDTH(6), .TERMS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .ain(ain4),
    .busy(busy4), .done(done4), .out(out4), .overflow(overflow4)
  );

  // Start is held across one rising edge; on return we are in cycle 1.
  task automatic launch(input bit use4, input logic [5:0] a);
    @(negedge clk);
    if (use4) begin ain4 = a; start4 = 1'b1; end
    else      begin ain  = a; start  = 1'b1; end
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
  endtask

  // Continues counting from cycle lat_in; leaves the DUT back in IDLE.
  task automatic wait_done(input bit use4, input int lat_in, output int lat,
                           output logic [5:0] o, output logic ov);
    lat = lat_in;
    while (!(use4 ? done4 : done) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    o  = use4 ? out4 : out;
    ov = use4 ? overflow4 : overflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0; ain = '0; ain4 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (out !== 6'd0)      begin errors++; $display("FAIL reset_out: got %0d want 0", out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int bc = 0;
    int dl = 0;
    logic [5:0] o = '0;
    logic ov = 1'b1;
    launch(1'b0, 6'd3);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (busy === 1'b1) bc++;
      if (done === 1'b1 && dl == 0) begin dl = c; o = out; ov = overflow; end
    end
    checks++; if (dl != 17)      begin errors++; $display("FAIL basic_latency: got %0d want 17", dl); end
    checks++; if (o !== 6'd8)    begin errors++; $display("FAIL basic_out: got %0d want 8", o); end
    checks++; if (ov !== 1'b0)   begin errors++; $display("FAIL basic_ovf: got %b want 0", ov); end
    checks++; if (bc != 17)      begin errors++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    checks++; if (out !== 6'd8)  begin errors++; $display("FAIL basic_out_held: got %0d want 8", out); end
  endtask

  task automatic test_zero();
    int lat; logic [5:0] o; logic ov;
    launch(1'b0, 6'd0);
    wait_done(1'b0, 1, lat, o, ov);
    checks++; if (lat != 9)    begin errors++; $display("FAIL zero_latency: got %0d want 9", lat); end
    checks++; if (o !== 6'd1)  begin errors++; $display("FAIL zero_out: got %0d want 1", o); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %b want 0", ov); end
  endtask

  task automatic test_early_stop();
    int lat; logic [5:0] o; logic ov;
    launch(1'b1, 6'd1);
    wait_done(1'b1, 1, lat, o, ov);
    checks++; if (lat != 17)   begin errors++; $display("FAIL early_latency: got %0d want 17", lat); end
    checks++; if (o !== 6'd2)  begin errors++; $display("FAIL early_out: got %0d want 2", o); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL early_ovf: got %b want 0", ov); end
  endtask

  task automatic test_mul_ovf();
    int lat; logic [5:0] o; logic ov;
    launch(1'b0, 6'd10);
    wait_done(1'b0, 1, lat, o, ov);
    checks++; if (lat > 17)         begin errors++; $display("FAIL mulovf_timeout: got %0d want <=17", lat); end
    checks++; if (o !== EXP_MUL_OVF) begin errors++; $display("FAIL mulovf_out: got %0d want %0d", o, EXP_MUL_OVF); end
    checks++; if (ov !== 1'b1)      begin errors++; $display("FAIL mulovf_ovf: got %b want 1", ov); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL mulovf_done_pulse: got %b want 0", done); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mulovf_ovf_held: got %b want 1", overflow); end
    checks++; if (out !== EXP_MUL_OVF) begin errors++; $display("FAIL mulovf_out_held: got %0d want %0d", out, EXP_MUL_OVF); end
  endtask

  task automatic test_add_ovf();
    int lat; logic [5:0] o; logic ov;
    launch(1'b0, 6'd63);
    wait_done(1'b0, 1, lat, o, ov);
    checks++; if (lat != 9)          begin errors++; $display("FAIL addovf_latency: got %0d want 9", lat); end
    checks++; if (o !== EXP_ADD_OVF) begin errors++; $display("FAIL addovf_out: got %0d want %0d", o, EXP_ADD_OVF); end
    checks++; if (ov !== 1'b1)       begin errors++; $display("FAIL addovf_ovf: got %b want 1", ov); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [5:0] o; logic ov;
    bit seen = 1'b0;
    launch(1'b0, 6'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; ain = 6'd5;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (out !== 6'd0)      begin errors++; $display("FAIL midrst_out: got %0d want 0", out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got activity=%b want 0", seen); end
    launch(1'b0, 6'd3);
    wait_done(1'b0, 1, lat, o, ov);
    checks++; if (lat != 17)  begin errors++; $display("FAIL postrst_latency: got %0d want 17", lat); end
    checks++; if (o !== 6'd8) begin errors++; $display("FAIL postrst_out: got %0d want 8", o); end
  endtask

  task automatic test_start_busy();
    int lat; logic [5:0] o; logic ov;
    launch(1'b0, 6'd3);
    repeat (4) @(posedge clk);
    @(negedge clk); ain = 6'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 6;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 17)    begin errors++; $display("FAIL busystart_latency: got %0d want 17", lat); end
    checks++; if (out !== 6'd8) begin errors++; $display("FAIL busystart_out: got %0d want 8", out); end
    // Start during the done cycle must also be dropped.
    @(negedge clk); ain = 6'd63; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL donestart_busy: got %b want 0", busy); end
    launch(1'b0, 6'd0);
    wait_done(1'b0, 1, lat, o, ov);
    checks++; if (lat != 9)   begin errors++; $display("FAIL b2b_latency: got %0d want 9", lat); end
    checks++; if (o !== 6'd1) begin errors++; $display("FAIL b2b_out: got %0d want 1", o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_early_stop();
    test_mul_ovf();
    test_add_ovf();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
